vend_controller: RTL and testbench
==================================

# vend_controller

Sequencing controller for the coin-operated vending machine. It accepts nickel, dime and quarter pulses and keeps a running credit. When the credit reaches the configured price it runs a request/acknowledge handshake with the item dispenser, then pays back any excess credit one nickel per cycle. It sits between the coin-acceptor front end and the dispenser/change-hopper drivers, and replaces the fixed-price accept-only state machine with priced vending, refund, timeout and change return.

## Interface

Parameters:
- PRICE, default 15: item price in cents; must be a nonzero multiple of 5 and ≤ MAX_CREDIT.
- MAX_CREDIT, default 40: highest credit held, in cents; multiple of 5, ≤ 60.
- TIMEOUT, default 255: idle cycles in CREDIT before an automatic refund; range 1..255.

Ports:
- clk, input, 1: single clock; everything updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- N, input, 1: nickel (5¢) pulse, one cycle per coin.
- D, input, 1: dime (10¢) pulse.
- Q, input, 1: quarter (25¢) pulse.
- cancel, input, 1: refund request, level sampled.
- disp_ack, input, 1: dispenser has released the item.
- disp_req, output, 1: dispense request.
- change_nickel, output, 1: return one nickel this cycle.
- coin_reject, output, 1: one-cycle pulse meaning the last sampled coin(s) were returned.
- credit, output, 6: current credit in cents, binary.
- busy, output, 1: high while in VEND or CHANGE.

## Operation

- States: IDLE, CREDIT, VEND, CHANGE. The state, credit and timer are registered; disp_req, change_nickel and busy are decoded from state only (Moore outputs).
- Reset values: state IDLE, credit 0, timer 0, disp_req 0, change_nickel 0, coin_reject 0, busy 0. Reset has priority over every other input.
- Coin acceptance rules:
  - A coin is accepted only in IDLE, or in CREDIT while credit < PRICE.
  - It must be the only coin line high that cycle.
  - credit + value must be ≤ MAX_CREDIT.
  - Any other coin activity is rejected: credit is unchanged and coin_reject pulses on the next cycle. Two or more coin lines high together reject all of them.
- IDLE:
  - An accepted coin sets credit to its value and moves to CREDIT.
  - cancel is ignored.
- CREDIT, checked in priority order against the registered credit:
  1. credit ≥ PRICE: go to VEND; any coin this cycle is rejected.
  2. cancel: go to CHANGE.
  3. Timer equals TIMEOUT: go to CHANGE.
  4. Accepted coin: credit += value, timer cleared.
  5. Otherwise: timer += 1.
- VEND:
  - disp_req is held high.
  - When disp_ack is sampled high: credit -= PRICE. If the result is nonzero go to CHANGE, else go to IDLE.
  - cancel is ignored; there is no timeout.
- CHANGE:
  - change_nickel is high every cycle.
  - Each edge does credit -= 5. On the edge where credit goes from 5 to 0, go to IDLE.
  - The number of change_nickel cycles equals credit/5 on entry.
- disp_ack outside VEND is ignored. The timer is cleared on every exit from CREDIT.
- Width: credit is 6 bits. Subtraction never underflows because credit is always a multiple of 5 and ≥ PRICE on the VEND exit.

## Timing

- Coin sampled at edge k: credit shows the new value after edge k, and the state changes at the same edge.
- Reaching PRICE takes one extra cycle in CREDIT, then VEND. disp_req first goes high one cycle after credit ≥ PRICE is visible.
- disp_ack sampled at edge m: disp_req is low after edge m, and the first change_nickel cycle starts after edge m.
- coin_reject is high for exactly one cycle, the cycle after the offending coin.
- Reset asserted mid-VEND or mid-CHANGE: at the next edge all outputs return to their reset values, remaining credit is discarded, and no further change is paid.

## Test plan

- N, then D one cycle later (PRICE 15) → credit 5, then 15. disp_req rises the next cycle. disp_ack held 2 cycles later → IDLE with credit 0, zero change_nickel cycles.
- Q from IDLE → credit 25, VEND, ack. After the ack: credit 10, two change_nickel cycles, then IDLE.
- D, then cancel → CHANGE. Two change_nickel cycles, then credit 0, IDLE.
- N and D high in the same cycle → coin_reject pulses once and credit stays 0. D during VEND → rejected, credit unchanged.
- MAX_CREDIT=30: D, then Q → Q rejected with credit staying 10. Then TIMEOUT=8 with no coins → CHANGE after 8 idle cycles, two change_nickel cycles.
- Reset asserted during the second change_nickel cycle after a Q vend → next cycle: credit 0, change_nickel 0, busy 0, IDLE. A new N is then accepted normally.

Source files
------------

// File: rtl/vend_controller.sv
// Coin-operated vending sequencer: credit accumulation, priced vend handshake,
// refund on cancel/timeout, and nickel-by-nickel change return.
module vend_controller #(
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 40,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       N,
  input  logic       D,
  input  logic       Q,
  input  logic       cancel,
  input  logic       disp_ack,
  output logic       disp_req,
  output logic       change_nickel,
  output logic       coin_reject,
  output logic [5:0] credit,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  localparam logic [5:0] LP_PRICE   = 6'(PRICE);
  localparam logic [5:0] LP_NICKEL  = 6'd5;
  localparam logic [6:0] LP_MAX     = 7'(MAX_CREDIT);
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t      r_state, w_state_nx;
  logic [5:0]  r_credit, w_credit_nx;
  logic [7:0]  r_timer, w_timer_nx;
  logic        r_reject, w_reject_nx;

  logic        w_any_coin, w_single_coin, w_accept;
  logic [5:0]  w_coin_val;
  logic [6:0]  w_sum;

  always_comb begin
    w_any_coin    = N | D | Q;
    w_single_coin = $onehot({N, D, Q});
    w_coin_val    = 6'd0;
    if (N)      w_coin_val = 6'd5;
    else if (D) w_coin_val = 6'd10;
    else if (Q) w_coin_val = 6'd25;
    // Widened by one bit so a quarter on top of a full credit cannot wrap.
    w_sum    = {1'b0, r_credit} + {1'b0, w_coin_val};
    w_accept = w_single_coin && (w_sum <= LP_MAX);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_credit <= 6'd0;
      r_timer  <= 8'd0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_credit <= w_credit_nx;
      r_timer  <= w_timer_nx;
      r_reject <= w_reject_nx;
    end
  end

  // Next-state logic; any coin not explicitly accepted below is rejected.
  always_comb begin
    w_state_nx  = r_state;
    w_credit_nx = r_credit;
    w_timer_nx  = 8'd0;
    w_reject_nx = w_any_coin;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_credit_nx = w_coin_val;
          w_state_nx  = S_CREDIT;
          w_reject_nx = 1'b0;
        end
      end
      S_CREDIT: begin
        if (r_credit >= LP_PRICE) begin
          w_state_nx = S_VEND;
        end else if (cancel) begin
          w_state_nx = S_CHANGE;
        end else if (r_timer == LP_TIMEOUT) begin
          w_state_nx = S_CHANGE;
        end else if (w_accept) begin
          w_credit_nx = w_sum[5:0];
          w_reject_nx = 1'b0;
        end else begin
          w_timer_nx = r_timer + 8'd1;
        end
      end
      S_VEND: begin
        if (disp_ack) begin
          w_credit_nx = r_credit - LP_PRICE;
          w_state_nx  = (r_credit == LP_PRICE) ? S_IDLE : S_CHANGE;
        end
      end
      S_CHANGE: begin
        w_credit_nx = r_credit - LP_NICKEL;
        if (r_credit <= LP_NICKEL) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    disp_req      = (r_state == S_VEND);
    change_nickel = (r_state == S_CHANGE);
    busy          = (r_state == S_VEND) || (r_state == S_CHANGE);
    coin_reject   = r_reject;
    credit        = r_credit;
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench: default-parameter instance plus a MAX_CREDIT=30 / TIMEOUT=8 instance.
module tb_vend_controller;

  logic clk = 1'b0;
  logic reset, N, D, Q, cancel, disp_ack;
  logic       a_disp_req, a_change, a_reject, a_busy;
  logic [5:0] a_credit;
  logic       b_disp_req, b_change, b_reject, b_busy;
  logic [5:0] b_credit;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vend_controller dut_a (
    .clk(clk), .reset(reset), .N(N), .D(D), .Q(Q), .cancel(cancel),
    .disp_ack(disp_ack), .disp_req(a_disp_req), .change_nickel(a_change),
    .coin_reject(a_reject), .credit(a_credit), .busy(a_busy)
  );

  vend_controller #(.PRICE(15), .MAX_CREDIT(30), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset), .N(N), .D(D), .Q(Q), .cancel(cancel),
    .disp_ack(disp_ack), .disp_req(b_disp_req), .change_nickel(b_change),
    .coin_reject(b_reject), .credit(b_credit), .busy(b_busy)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; N = 0; D = 0; Q = 0; cancel = 0; disp_ack = 0;
    do_reset();
    check_eq("rst_credit", a_credit, 0);
    check_eq("rst_req", a_disp_req, 0);
    check_eq("rst_chg", a_change, 0);
    check_eq("rst_rej", a_reject, 0);
    check_eq("rst_busy", a_busy, 0);

    // N then D: exact price, no change
    N = 1; tick(); N = 0;
    check_eq("nd_credit5", a_credit, 5);
    D = 1; tick(); D = 0;
    check_eq("nd_credit15", a_credit, 15);
    check_eq("nd_req_lo", a_disp_req, 0);
    tick();
    check_eq("nd_req_hi", a_disp_req, 1);
    check_eq("nd_busy", a_busy, 1);
    tick();
    check_eq("nd_req_hold", a_disp_req, 1);
    disp_ack = 1; tick(); disp_ack = 0;
    check_eq("nd_credit0", a_credit, 0);
    check_eq("nd_req_off", a_disp_req, 0);
    check_eq("nd_nochg", a_change, 0);
    tick();
    check_eq("nd_nochg2", a_change, 0);
    check_eq("nd_idle_busy", a_busy, 0);

    // Q: vend then two nickels change
    Q = 1; tick(); Q = 0;
    check_eq("q_credit25", a_credit, 25);
    tick();
    check_eq("q_req", a_disp_req, 1);
    disp_ack = 1; tick(); disp_ack = 0;
    check_eq("q_credit10", a_credit, 10);
    check_eq("q_chg1", a_change, 1);
    check_eq("q_req_off", a_disp_req, 0);
    tick();
    check_eq("q_credit5", a_credit, 5);
    check_eq("q_chg2", a_change, 1);
    tick();
    check_eq("q_credit0", a_credit, 0);
    check_eq("q_chg_done", a_change, 0);
    check_eq("q_busy", a_busy, 0);

    // D then cancel: refund
    D = 1; tick(); D = 0;
    check_eq("c_credit10", a_credit, 10);
    cancel = 1; tick(); cancel = 0;
    check_eq("c_chg1", a_change, 1);
    check_eq("c_credit", a_credit, 10);
    tick();
    check_eq("c_chg2", a_change, 1);
    check_eq("c_credit5", a_credit, 5);
    tick();
    check_eq("c_chg_done", a_change, 0);
    check_eq("c_credit0", a_credit, 0);

    // Two coins at once: rejected
    N = 1; D = 1; tick(); N = 0; D = 0;
    check_eq("m_rej", a_reject, 1);
    check_eq("m_credit", a_credit, 0);
    tick();
    check_eq("m_rej_off", a_reject, 0);

    // Coin during VEND rejected
    D = 1; tick(); D = 0;
    N = 1; tick(); N = 0;
    check_eq("v_credit15", a_credit, 15);
    tick();
    check_eq("v_req", a_disp_req, 1);
    D = 1; tick(); D = 0;
    check_eq("v_rej", a_reject, 1);
    check_eq("v_credit", a_credit, 15);
    check_eq("v_req_hold", a_disp_req, 1);
    disp_ack = 1; tick(); disp_ack = 0;
    check_eq("v_rej_off", a_reject, 0);
    check_eq("v_credit0", a_credit, 0);

    // MAX_CREDIT=30 overflow reject, then timeout refund (instance B)
    do_reset();
    D = 1; tick(); D = 0;
    check_eq("b_credit10", b_credit, 10);
    Q = 1; tick(); Q = 0;
    check_eq("b_rej", b_reject, 1);
    check_eq("b_credit_keep", b_credit, 10);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq("b_wait_nochg", b_change, 0);
    end
    tick();
    check_eq("b_to_chg1", b_change, 1);
    check_eq("b_to_credit", b_credit, 10);
    tick();
    check_eq("b_to_chg2", b_change, 1);
    check_eq("b_to_credit5", b_credit, 5);
    tick();
    check_eq("b_to_done", b_change, 0);
    check_eq("b_to_credit0", b_credit, 0);

    // Reset mid-change
    do_reset();
    Q = 1; tick(); Q = 0;
    tick();
    disp_ack = 1; tick(); disp_ack = 0;
    check_eq("r_chg1", a_change, 1);
    tick();
    check_eq("r_chg2", a_change, 1);
    check_eq("r_credit5", a_credit, 5);
    reset = 1; tick(); reset = 0;
    check_eq("r_credit0", a_credit, 0);
    check_eq("r_chg_off", a_change, 0);
    check_eq("r_busy", a_busy, 0);
    check_eq("r_req", a_disp_req, 0);
    N = 1; tick(); N = 0;
    check_eq("r_n_credit", a_credit, 5);
    check_eq("r_n_rej", a_reject, 0);
    tick();
    check_eq("r_n_hold", a_credit, 5);
    check_eq("r_n_busy", a_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
